// File: rtl/fifo_arb_pkg.sv
// Shared constants and the round-robin search helper for the FIFO write-port arbiter.
package fifo_arb_pkg;

    localparam int unsigned DEF_N_REQ     = 4;
    localparam int unsigned DEF_MAX_BURST = 4;
    localparam int unsigned RR_MAX_REQ    = 64;
    localparam int unsigned RR_IDX_W      = 6;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // First set bit of req searching cyclically from last_id+1; returns last_id if none set.
    function automatic int unsigned rr_next_id(
        input logic [RR_MAX_REQ-1:0] req,
        input int unsigned           last_id,
        input int unsigned           n_req
    );
        int unsigned idx;
        logic        found;
        rr_next_id = last_id;
        found      = 1'b0;
        for (int unsigned i = 1; i <= RR_MAX_REQ; i++) begin
            idx = last_id + i;
            if (idx >= n_req) begin
                idx = idx - n_req;
            end
            if ((i <= n_req) && !found && req[idx[RR_IDX_W-1:0]]) begin
                rr_next_id = idx;
                found      = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: picks the next requester after i_last_id.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ    = DEF_N_REQ,
    parameter int unsigned ID_WIDTH = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]    i_req,
    input  logic [ID_WIDTH-1:0] i_last_id,
    output logic                o_valid,
    output logic [ID_WIDTH-1:0] o_id,
    output logic [N_REQ-1:0]    o_onehot
);

    logic [RR_MAX_REQ-1:0] w_req_ext;
    int unsigned           w_next;

    assign w_req_ext = RR_MAX_REQ'(i_req);
    assign w_next    = rr_next_id(w_req_ext, 32'(i_last_id), N_REQ);
    assign o_valid   = |i_req;
    assign o_id      = ID_WIDTH'(w_next);
    assign o_onehot  = o_valid ? (N_REQ'(1) << o_id) : '0;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: grants one producer at a time for a bounded burst
// and drives the shared FIFO write port, honouring full backpressure.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = DEF_N_REQ,
    parameter int unsigned SIZE_DATA = 8,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST,
    parameter int unsigned ID_WIDTH  = $clog2(N_REQ)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ*SIZE_DATA-1:0] i_data,
    output logic [N_REQ-1:0]           o_ack,
    output logic [N_REQ-1:0]           o_grant,
    output logic [ID_WIDTH-1:0]        o_grant_id,
    output logic                       o_busy,
    output logic                       o_fifo_wr_en,
    output logic [SIZE_DATA-1:0]       o_fifo_data,
    input  logic                       i_fifo_full
);

    localparam int unsigned         CNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [ID_WIDTH-1:0] ID_LAST  = ID_WIDTH'(N_REQ - 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(MAX_BURST - 1);

    logic [0:0]          r_state;
    logic [N_REQ-1:0]    r_grant;
    logic [ID_WIDTH-1:0] r_grant_id;
    logic [CNT_W-1:0]    r_burst_cnt;
    logic                r_busy;

    logic [0:0]          w_state_nxt;
    logic [N_REQ-1:0]    w_grant_nxt;
    logic [ID_WIDTH-1:0] w_grant_id_nxt;
    logic [CNT_W-1:0]    w_burst_nxt;

    logic                w_pick_valid;
    logic [ID_WIDTH-1:0] w_pick_id;
    logic [N_REQ-1:0]    w_pick_onehot;
    logic                w_in_grant;
    logic                w_req_g;
    logic                w_xfer;

    rr_pick #(
        .N_REQ    (N_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_pick (
        .i_req     (i_req),
        .i_last_id (r_grant_id),
        .o_valid   (w_pick_valid),
        .o_id      (w_pick_id),
        .o_onehot  (w_pick_onehot)
    );

    // A word moves only while granted, the owner still requests and the FIFO has room.
    assign w_in_grant   = (r_state == ST_GRANT);
    assign w_req_g      = i_req[r_grant_id];
    assign w_xfer       = w_in_grant & w_req_g & ~i_fifo_full & ~i_rst;

    assign o_fifo_wr_en = w_xfer;
    assign o_ack        = w_xfer ? r_grant : '0;
    assign o_fifo_data  = i_data[r_grant_id*SIZE_DATA +: SIZE_DATA];
    assign o_grant      = r_grant;
    assign o_grant_id   = r_grant_id;
    assign o_busy       = r_busy;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_grant_id  <= ID_LAST;
            r_burst_cnt <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_grant_id  <= w_grant_id_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_busy      <= (w_state_nxt == ST_GRANT);
        end
    end

    // Grant id is kept on exit so the next search starts after the last owner.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_grant_id_nxt = r_grant_id;
        w_burst_nxt    = r_burst_cnt;
        if (r_state == ST_IDLE) begin
            if (w_pick_valid) begin
                w_state_nxt    = ST_GRANT;
                w_grant_nxt    = w_pick_onehot;
                w_grant_id_nxt = w_pick_id;
                w_burst_nxt    = '0;
            end
        end else begin
            if (w_xfer) begin
                w_burst_nxt = r_burst_cnt + CNT_W'(1);
            end
            if (!w_req_g || (w_xfer && (r_burst_cnt == CNT_LAST))) begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_burst_nxt = '0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: requesters and FIFO are modelled in the bench,
// expected write order comes from a transaction-level round-robin model.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int MB    = 4;
    localparam int DEPTH = 8;
    localparam int IDW   = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   d;
    } exp_t;

    logic           clk = 1'b0;
    logic           tb_rst;
    logic [N-1:0]   tb_req;
    logic [N*W-1:0] tb_data;
    logic           tb_full;
    logic [N-1:0]   o_ack;
    logic [N-1:0]   o_grant;
    logic [IDW-1:0] o_grant_id;
    logic           o_busy;
    logic           o_fifo_wr_en;
    logic [W-1:0]   o_fifo_data;

    exp_t       expq[$];
    logic [7:0] mem [N][16];
    int         head [N];
    int         cnt  [N];
    logic       en   [N];
    int         fcnt;
    int         pop_pct;
    logic       rd_s;
    logic [N-1:0] ack_s;
    logic       wr_s;
    int         checks;
    int         failures;
    logic [N-1:0] prev_grant;
    logic       prev_idle_req;
    int         model_last;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .N_REQ     (N),
        .SIZE_DATA (W),
        .MAX_BURST (MB),
        .ID_WIDTH  (IDW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (tb_rst),
        .i_req        (tb_req),
        .i_data       (tb_data),
        .o_ack        (o_ack),
        .o_grant      (o_grant),
        .o_grant_id   (o_grant_id),
        .o_busy       (o_busy),
        .o_fifo_wr_en (o_fifo_wr_en),
        .o_fifo_data  (o_fifo_data),
        .i_fifo_full  (tb_full)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every word written to the FIFO must be the next scoreboard entry.
    always @(negedge clk) begin
        exp_t         e;
        logic [N-1:0] oh;
        if (tb_rst) begin
            ack_s         = '0;
            wr_s          = 1'b0;
            prev_grant    = '0;
            prev_idle_req = 1'b0;
        end else begin
            ack_s = o_ack;
            wr_s  = o_fifo_wr_en;
            if (o_fifo_wr_en) begin
                chk("wr_while_full", 32'(tb_full), 32'(0));
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got id=%0d data=0x%0h required no write",
                             o_grant_id, o_fifo_data);
                end else begin
                    e  = expq.pop_front();
                    oh = '0;
                    oh[e.id] = 1'b1;
                    chk("wr_id", 32'(o_grant_id), 32'(e.id));
                    chk("wr_data", 32'(o_fifo_data), 32'(e.d));
                    chk("ack_onehot", 32'(o_ack), 32'(oh));
                    chk("grant_onehot", 32'(o_grant), 32'(oh));
                end
            end else begin
                chk("ack_no_write", 32'(o_ack), 32'(0));
            end
            if (prev_grant != '0 && o_grant != '0) begin
                chk("idle_gap", 32'(o_grant), 32'(prev_grant));
            end
            if (prev_idle_req) begin
                chk("arb_latency", 32'(o_grant != '0), 32'(1));
            end
            prev_idle_req = (o_grant == '0) && (tb_req != '0);
            prev_grant    = o_grant;
        end
    end

    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            tb_req[k]          = (cnt[k] > 0) && en[k];
            tb_data[k*W +: W]  = mem[k][head[k] & 15];
        end
        tb_full = (fcnt >= DEPTH);
    endtask

    // One clock: apply what the DUT accepted at this edge, then update requesters and FIFO.
    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (ack_s[k] && cnt[k] > 0) begin
                head[k]++;
                cnt[k]--;
            end
        end
        if (wr_s && fcnt < DEPTH) fcnt++;
        if (rd_s && fcnt > 0) fcnt--;
        rd_s = (fcnt > 0) && ($urandom_range(99) < pop_pct);
        drive_inputs();
    endtask

    task automatic load_words(input int k, input int n, input logic [7:0] base, input bit rnd);
        for (int i = 0; i < 16; i++) begin
            mem[k][i] = rnd ? 8'($urandom) : 8'(base + 8'(i));
        end
        head[k] = 0;
        cnt[k]  = n;
    endtask

    // Transaction-level model: requesters with words are served cyclically after the
    // last owner, each taking up to MB words per turn.
    task automatic push_model();
        int  rem [N];
        int  pos [N];
        int  last;
        int  k;
        int  m;
        bit  any;
        bit  found;
        last = model_last;
        for (int i = 0; i < N; i++) begin
            rem[i] = cnt[i];
            pos[i] = head[i];
        end
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            for (int i = 0; i < N; i++) if (rem[i] > 0) any = 1'b1;
            found = 1'b0;
            for (int s = 1; s <= N; s++) begin
                k = (last + s) % N;
                if (any && !found && rem[k] > 0) begin
                    m = (rem[k] < MB) ? rem[k] : MB;
                    for (int j = 0; j < m; j++) begin
                        expq.push_back(exp_t'{id: IDW'(k), d: mem[k][(pos[k] + j) & 15]});
                    end
                    rem[k] -= m;
                    pos[k] += m;
                    last    = k;
                    found   = 1'b1;
                end
            end
        end
        model_last = last;
    endtask

    function automatic bit pending();
        pending = (expq.size() != 0);
        for (int k = 0; k < N; k++) if (cnt[k] > 0) pending = 1'b1;
    endfunction

    task automatic run_until_done(input string tag);
        int n;
        n = 0;
        while (pending() && n < 3000) begin
            step();
            n++;
        end
        checks++;
        if (n >= 3000) begin
            failures++;
            $display("FAIL drain_%s: %0d words still expected after %0d cycles, required 0",
                     tag, expq.size(), n);
            expq.delete();
            for (int k = 0; k < N; k++) cnt[k] = 0;
        end
        repeat (3) step();
    endtask

    // Caller sits just after a rising edge; reset is raised between edges.
    task automatic do_reset();
        #3;
        tb_rst = 1'b1;
        #1;
        chk("rst_grant", 32'(o_grant), 32'(0));
        chk("rst_grant_id", 32'(o_grant_id), 32'(N - 1));
        chk("rst_busy", 32'(o_busy), 32'(0));
        chk("rst_wr_en", 32'(o_fifo_wr_en), 32'(0));
        chk("rst_ack", 32'(o_ack), 32'(0));
        expq.delete();
        for (int k = 0; k < N; k++) begin
            cnt[k]  = 0;
            head[k] = 0;
            en[k]   = 1'b1;
        end
        fcnt       = 0;
        rd_s       = 1'b0;
        model_last = N - 1;
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        tb_rst = 1'b0;
        step();
    endtask

    initial begin
        int c;
        checks   = 0;
        failures = 0;
        tb_rst   = 1'b1;
        tb_req   = '0;
        tb_data  = '0;
        tb_full  = 1'b0;
        pop_pct  = 100;
        ack_s    = '0;
        wr_s     = 1'b0;
        rd_s     = 1'b0;
        fcnt     = 0;
        for (int k = 0; k < N; k++) begin
            en[k] = 1'b1;
            cnt[k] = 0;
            head[k] = 0;
            for (int i = 0; i < 16; i++) mem[k][i] = '0;
        end
        @(posedge clk);
        #1;
        do_reset();

        // Single requester, 6 words: two bursts 4+2.
        load_words(0, 6, 8'h10, 1'b0);
        push_model();
        drive_inputs();
        run_until_done("single");

        // All four from reset, 2 words each: order 0,1,2,3.
        do_reset();
        for (int k = 0; k < N; k++) load_words(k, 2, 8'(k * 16), 1'b0);
        push_model();
        drive_inputs();
        run_until_done("all4");

        // After a grant to 1, requesters 1 and 3 alternate starting with 3.
        load_words(1, 1, 8'h90, 1'b0);
        push_model();
        drive_inputs();
        run_until_done("pre1");
        load_words(1, 6, 8'hA0, 1'b0);
        load_words(3, 6, 8'hB0, 1'b0);
        push_model();
        drive_inputs();
        run_until_done("alt13");

        // FIFO at 7 words: one write, then stall until the bench pops.
        fcnt    = 7;
        pop_pct = 0;
        rd_s    = 1'b0;
        load_words(2, 3, 8'h40, 1'b0);
        push_model();
        drive_inputs();
        c = 0;
        while (fcnt < DEPTH && c < 20) begin
            step();
            c++;
        end
        chk("full_reached", 32'(fcnt), 32'(DEPTH));
        chk("full_one_word", 32'(cnt[2]), 32'(2));
        repeat (4) begin
            step();
            chk("stall_wr_en", 32'(o_fifo_wr_en), 32'(0));
            chk("stall_ack", 32'(o_ack), 32'(0));
            chk("stall_grant", 32'(o_grant), 32'(4'b0100));
        end
        chk("stall_words_left", 32'(cnt[2]), 32'(2));
        pop_pct = 100;
        run_until_done("full");

        // Reset mid-burst of requester 1, then requester 0 wins first.
        do_reset();
        load_words(1, 6, 8'h50, 1'b0);
        push_model();
        drive_inputs();
        c = 0;
        while (cnt[1] > 4 && c < 50) begin
            step();
            c++;
        end
        chk("mid_two_words", 32'(cnt[1]), 32'(4));
        chk("mid_inflight", 32'(o_fifo_wr_en), 32'(1));
        do_reset();
        load_words(0, 2, 8'h01, 1'b0);
        load_words(1, 2, 8'h11, 1'b0);
        push_model();
        drive_inputs();
        run_until_done("post_rst");

        // Owner releases after one word; pending requester 2 granted one cycle after exit.
        do_reset();
        load_words(1, 3, 8'h60, 1'b0);
        load_words(2, 2, 8'h70, 1'b0);
        expq.push_back(exp_t'{id: 2'd1, d: 8'h60});
        expq.push_back(exp_t'{id: 2'd2, d: 8'h70});
        expq.push_back(exp_t'{id: 2'd2, d: 8'h71});
        expq.push_back(exp_t'{id: 2'd1, d: 8'h61});
        expq.push_back(exp_t'{id: 2'd1, d: 8'h62});
        drive_inputs();
        c = 0;
        while (cnt[1] > 2 && c < 50) begin
            step();
            c++;
        end
        en[1] = 1'b0;
        drive_inputs();
        @(negedge clk);
        chk("rel_still_granted", 32'(o_grant), 32'(4'b0010));
        step();
        @(negedge clk);
        chk("rel_idle", 32'(o_grant), 32'(0));
        chk("rel_idle_busy", 32'(o_busy), 32'(0));
        step();
        @(negedge clk);
        chk("rel_next_grant", 32'(o_grant), 32'(4'b0100));
        chk("rel_next_id", 32'(o_grant_id), 32'(2));
        chk("rel_next_busy", 32'(o_busy), 32'(1));
        en[1] = 1'b1;
        drive_inputs();
        run_until_done("release");
        model_last = 1;

        // Randomised batches with random backpressure.
        for (int b = 0; b < 30; b++) begin
            pop_pct = int'($urandom_range(10, 100));
            for (int k = 0; k < N; k++) begin
                load_words(k, int'($urandom_range(0, 7)), 8'h00, 1'b1);
            end
            push_model();
            drive_inputs();
            run_until_done("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that lets N_REQ producers share one fifo_synchronous instance.
- Grants one requester at a time for a bounded burst of words.
- Muxes the granted requester's data onto the FIFO write port and returns a per-word acknowledge.
- Honours FIFO full backpressure. Sits directly in front of the FIFO i_wr_en/i_data inputs.

Parameters:
- N_REQ, 4, number of requesters (>=2)
- SIZE_DATA, 8, data word width; must match the FIFO's SIZE_DATA
- MAX_BURST, 4, maximum words per grant (>=1)
- ID_WIDTH, $clog2(N_REQ), width of the grant index

Ports:
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst  in  1  reset; asynchronous, active-high
- i_req  in  N_REQ  per-requester request; held high while the requester has a valid word
- i_data  in  N_REQ*SIZE_DATA  packed requester data; requester k occupies bits [k*SIZE_DATA +: SIZE_DATA]
- o_ack  out  N_REQ  one-hot, combinational; word accepted this cycle, so the requester advances its data next cycle
- o_grant  out  N_REQ  registered one-hot current owner; 0 when idle
- o_grant_id  out  ID_WIDTH  registered index of the current or last owner
- o_busy  out  1  high while in GRANT
- o_fifo_wr_en  out  1  FIFO write enable, combinational
- o_fifo_data  out  SIZE_DATA  FIFO write data: i_data slice of o_grant_id
- i_fifo_full  in  1  FIFO o_full

Behaviour:

Reset (async on i_rst=1):
- state=IDLE, o_grant=0, o_grant_id=N_REQ-1 (so requester 0 wins first), burst_cnt=0, o_busy=0.
- o_ack=0 and o_fifo_wr_en=0 while in reset.
- Reset mid-burst aborts immediately; the word in flight that cycle is not written.

States:
- IDLE:
  - o_ack=0, o_fifo_wr_en=0.
  - If |i_req, go to GRANT next edge.
  - Winner = first set bit of i_req, searching cyclically from o_grant_id+1 (wraps N_REQ-1 -> 0).
  - Load o_grant/o_grant_id, clear burst_cnt.
  - Arbitration latency is 1 cycle: the first word can be written in the cycle after the request is seen in IDLE.
- GRANT, with g = o_grant_id:
  - xfer = i_req[g] & ~i_fifo_full.
  - o_fifo_wr_en = xfer; o_ack[g] = xfer; o_fifo_data = i_data slice g regardless of xfer.
  - On xfer: burst_cnt++.
  - Exit to IDLE (o_grant<=0, o_grant_id retained) when either:
    - i_req[g]=0 (requester released), or
    - xfer and burst_cnt==MAX_BURST-1 (last word of burst).
  - i_fifo_full=1 with i_req[g]=1: stall. Stay in GRANT, no write, no ack, burst_cnt unchanged, no timeout.
  - Requests from other requesters are ignored during GRANT.
- Back-to-back: every grant is preceded by one IDLE cycle, so throughput is at most MAX_BURST words per MAX_BURST+1 cycles.
- Fairness: after a grant to k, k has lowest priority at the next arbitration. With all requesters active, each is served within N_REQ grants.
- burst_cnt width: $clog2(MAX_BURST+1). It never exceeds MAX_BURST-1.
- Never assert o_fifo_wr_en while i_fifo_full=1. The FIFO's own overflow guard must not be relied upon.

Decomposition:
- Package fifo_arb_pkg:
  - state enum {IDLE, GRANT}
  - localparam defaults for N_REQ, MAX_BURST
  - function rr_next_id(req, last_id)
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req[N_REQ], last_id.
  - Outputs: valid, id, onehot.
  - Instantiated once. The arbiter holds all sequential state.

Test Plan:
All cases use N_REQ=4, SIZE_DATA=8, MAX_BURST=4, FIFO depth 8, with the arbiter driving fifo_synchronous.
1. Reset only requester 0 with 0x10..0x15 (6 words), held -> grant 0 writes 0x10-0x13, one IDLE cycle, re-grant 0, writes 0x14-0x15, then releases. FIFO holds 0x10..0x15 in order.
2. Requesters 0-3 request simultaneously from reset, each supplying 2 words (k0,k1) -> grant order 0,1,2,3. FIFO contents 00,01,10,11,20,21,30,31. Each grant lasts 2 xfers.
3. Requesters 1 and 3 continuously request (>4 words each) after a grant to 1 -> grants alternate 3,1,3,… Each burst is exactly 4 writes.
4. FIFO pre-filled to 7 words, requester 2 requests 3 words -> one write, i_fifo_full=1, o_ack/o_fifo_wr_en stay 0. After the bench pops 2 words, the remaining 2 words are written. No write ever occurs while full.
5. Assert i_rst mid-burst after 2 words of requester 1 (asynchronously, between edges) -> o_grant=0, o_fifo_wr_en=0 in the same cycle. After release, requester 0 (if requesting) wins first.
6. Granted requester drops i_req after 1 word -> exit to IDLE on the next edge. Requester 2, pending, is granted one cycle later. o_grant_id sequence 1->2.
